icache_fill_unit: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory arbiter.
- Serves fetch requests combinationally on a hit.
- On a miss, runs a two-word block-fill state machine against memory.
- Keeps hit and miss performance counters.
- The fetch stage holds imemREN/imemaddr stable until ihit.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_frame_array.sv | 50 +++++
 rtl/icache_fill_unit.sv | 130 +++++++++++++
 tb/tb_icache_fill_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned WORD_W = 32;
  // Line address is the word address without the block offset: addr[31:3].
  localparam int unsigned LINE_W = WORD_W - 3;

  localparam int unsigned SETS_DEFAULT  = 8;
  localparam int unsigned IDX_W_DEFAULT = $clog2(SETS_DEFAULT);
  localparam int unsigned TAG_W_DEFAULT = LINE_W - IDX_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1
  } icache_state_t;

  // Tag is stored zero-extended to LINE_W so the struct is independent of SETS.
  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] tag;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
  } icache_frame_t;

  function automatic int unsigned idx_width(input int unsigned sets);
    return (sets <= 2) ? 1 : $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// SETS-entry frame store: one write port, one combinational read port, async clear.
module icache_frame_array
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic              i_we,
  input  logic              i_wsel,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_set_valid,
  input  logic [LINE_W-1:0] i_wtag,
  input  logic              i_clr_valid,
  input  logic [IDX_W-1:0]  i_ridx,
  output icache_frame_t     o_rframe
);

  icache_frame_t r_frames [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        r_frames[i] <= '0;
      end
    end else begin
      if (i_clr_valid) begin
        r_frames[i_widx].valid <= 1'b0;
      end
      if (i_we) begin
        if (i_wsel) begin
          r_frames[i_widx].word1 <= i_wdata;
        end else begin
          r_frames[i_widx].word0 <= i_wdata;
        end
      end
      if (i_set_valid) begin
        r_frames[i_widx].valid <= 1'b1;
        r_frames[i_widx].tag   <= i_wtag;
      end
    end
  end

  always_comb begin
    o_rframe = r_frames[i_ridx];
  end

endmodule

// File: rtl/icache_fill_unit.sv
// Direct-mapped read-only icache: zero-latency hit path, two-word block fill on miss.
module icache_fill_unit
  import icache_pkg::*;
#(
  parameter int unsigned SETS   = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
);

  localparam int unsigned IDX_W = idx_width(SETS);

  icache_state_t     r_state, w_state_next;
  logic [LINE_W-1:0] r_fill_line;
  logic [WORD_W-1:0] r_hit_count, r_miss_count;

  logic [IDX_W-1:0]  w_idx, w_fill_idx, w_widx;
  logic [LINE_W-1:0] w_line, w_tag, w_fill_tag;
  icache_frame_t     w_rframe;
  logic              w_hit, w_miss;
  logic              w_we, w_wsel, w_set_valid, w_clr_valid;
  logic              w_unused;

  assign w_unused   = ^imemaddr[1:0];
  assign w_line     = imemaddr[WORD_W-1:3];
  assign w_idx      = w_line[IDX_W-1:0];
  assign w_tag      = w_line >> IDX_W;
  assign w_fill_idx = r_fill_line[IDX_W-1:0];
  assign w_fill_tag = r_fill_line >> IDX_W;

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W)
  ) u_frames (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_widx      (w_widx),
    .i_we        (w_we),
    .i_wsel      (w_wsel),
    .i_wdata     (iload),
    .i_set_valid (w_set_valid),
    .i_wtag      (w_fill_tag),
    .i_clr_valid (w_clr_valid),
    .i_ridx      (w_idx),
    .o_rframe    (w_rframe)
  );

  always_comb begin
    w_hit    = imemREN && (r_state == IDLE) && w_rframe.valid && (w_rframe.tag == w_tag);
    w_miss   = imemREN && (r_state == IDLE) && !w_hit;
    ihit     = w_hit;
    imemload = '0;
    if (w_hit) begin
      imemload = imemaddr[2] ? w_rframe.word1 : w_rframe.word0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    iREN         = 1'b0;
    iaddr        = '0;
    w_widx       = w_fill_idx;
    w_we         = 1'b0;
    w_wsel       = 1'b0;
    w_set_valid  = 1'b0;
    w_clr_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          // Invalidate the victim now so a half-filled frame can never hit.
          w_widx       = w_idx;
          w_clr_valid  = 1'b1;
          w_state_next = FILL0;
        end
      end
      FILL0: begin
        iREN  = 1'b1;
        iaddr = {r_fill_line, 3'b000};
        if (!iwait) begin
          w_we         = 1'b1;
          w_state_next = FILL1;
        end
      end
      FILL1: begin
        iREN  = 1'b1;
        iaddr = {r_fill_line, 3'b100};
        if (!iwait) begin
          w_we         = 1'b1;
          w_wsel       = 1'b1;
          w_set_valid  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_fill_line  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss) begin
        r_fill_line  <= w_line;
        r_miss_count <= r_miss_count + 1'b1;
      end
      if (w_hit) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_fill_unit.sv
// Self-checking bench for icache_fill_unit: behavioural cache model plus a stalling memory.
module tb_icache_fill_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 CLK = ~CLK;

  icache_fill_unit #(.SETS(8), .WORD_W(32)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00} ^ 32'hA5A5_0000;
    return w * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign iload = mem_word(iaddr);

  // Memory: each requested word is held off for stall_n cycles, then accepted.
  int unsigned stall_n = 0;
  int unsigned wcnt    = 0;
  always @(negedge CLK) begin
    if (iREN === 1'b1) begin
      if (wcnt < stall_n) begin
        iwait = 1'b1;
        wcnt++;
      end else begin
        iwait = 1'b0;
        wcnt  = 0;
      end
    end else begin
      iwait = 1'b0;
      wcnt  = 0;
    end
  end

  // Reference model: what each set holds, and the counters the DUT should show.
  bit          m_valid [8];
  logic [25:0] m_tag   [8];
  logic [31:0] m_w0    [8];
  logic [31:0] m_w1    [8];
  int unsigned m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int unsigned st, output bit missed);
    int unsigned idx;
    bit          exp_hit;
    logic [31:0] base, exp_addr, exp_data;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = a;
    stall_n  = st;
    idx      = a[5:3];
    exp_hit  = m_valid[idx] && (m_tag[idx] == a[31:6]);
    missed   = !exp_hit;
    base     = {a[31:3], 3'b000};
    @(negedge CLK); #1;
    n_cmp++;
    if (ihit !== exp_hit) begin
      n_fail++;
      $display("FAIL fetch_ihit addr=%h: got %b expected %b", a, ihit, exp_hit);
    end
    if (exp_hit) begin
      exp_data = a[2] ? m_w1[idx] : m_w0[idx];
      n_cmp++;
      if (imemload !== exp_data) begin
        n_fail++;
        $display("FAIL hit_data addr=%h: got %h expected %h", a, imemload, exp_data);
      end
      m_hits++;
    end else begin
      m_misses++;
      m_valid[idx] = 1'b0;
      for (int c = 1; c <= 2 * (int'(st) + 1); c++) begin
        @(negedge CLK); #1;
        exp_addr = (c <= int'(st) + 1) ? base : base + 32'd4;
        n_cmp++;
        if (iREN !== 1'b1 || iaddr !== exp_addr || ihit !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_cycle addr=%h c=%0d: got iREN=%b iaddr=%h ihit=%b expected 1 %h 0",
                   a, c, iREN, iaddr, ihit, exp_addr);
        end
      end
      @(negedge CLK); #1;
      n_cmp++;
      if (ihit !== 1'b1 || imemload !== mem_word(a) || iREN !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_done addr=%h: got ihit=%b data=%h iREN=%b expected 1 %h 0",
                 a, ihit, imemload, iREN, mem_word(a));
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:6];
      m_w0[idx]    = mem_word(base);
      m_w1[idx]    = mem_word(base + 32'd4);
      m_hits++;
    end
  endtask

  task automatic check_counters(input string tag);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK); #1;
    n_cmp++;
    if (hit_count !== m_hits || miss_count !== m_misses) begin
      n_fail++;
      $display("FAIL counters_%s: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
               tag, hit_count, miss_count, m_hits, m_misses);
    end
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    model_reset();
    #22;
    n_cmp++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0 ||
        hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ihit=%b iREN=%b iaddr=%h load=%h hc=%0d mc=%0d expected all 0",
               ihit, iREN, iaddr, imemload, hit_count, miss_count);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_and_spatial();
    bit missed;
    do_fetch(32'h40, 0, missed);
    check_counters("cold");
    do_fetch(32'h44, 0, missed);
    n_cmp++;
    if (missed) begin
      n_fail++;
      $display("FAIL spatial_hit: got miss expected hit for 0x44");
    end
    check_counters("spatial");
  endtask

  task automatic test_conflict();
    bit missed;
    do_fetch(32'h240, 0, missed);
    do_fetch(32'h244, 0, missed);
    do_fetch(32'h40, 0, missed);
    n_cmp++;
    if (!missed || m_misses != 3) begin
      n_fail++;
      $display("FAIL conflict_evict: got missed=%b misses=%0d expected 1 3", missed, m_misses);
    end
    check_counters("conflict");
  endtask

  task automatic test_stall();
    bit missed;
    do_fetch(32'h100, 3, missed);
    check_counters("stall");
  endtask

  task automatic test_reset_mid_fill();
    bit missed;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    stall_n  = 2;
    repeat (5) @(negedge CLK);
    #1;
    n_cmp++;
    if (iREN !== 1'b1 || iaddr !== 32'h84) begin
      n_fail++;
      $display("FAIL mid_fill_setup: got iREN=%b iaddr=%h expected 1 00000084", iREN, iaddr);
    end
    #1 nRST = 1'b0;
    #1;
    n_cmp++;
    if (iREN !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0 || ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill_reset: got iREN=%b hc=%0d mc=%0d ihit=%b expected 0 0 0 0",
               iREN, hit_count, miss_count, ihit);
    end
    model_reset();
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    do_fetch(32'h80, 1, missed);
    n_cmp++;
    if (!missed) begin
      n_fail++;
      $display("FAIL refetch_after_reset: got hit expected miss for 0x80");
    end
    check_counters("after_reset");
  endtask

  task automatic test_idle();
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      imemREN  = 1'b0;
      imemaddr = $urandom;
      @(negedge CLK); #1;
      n_cmp++;
      if (iREN !== 1'b0 || ihit !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_cycle %0d: got iREN=%b ihit=%b expected 0 0", i, iREN, ihit);
      end
      @(posedge CLK); #1;
    end
    check_counters("idle");
  endtask

  task automatic test_random();
    bit          missed;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 3) |
          ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      do_fetch(a, $urandom_range(0, 2), missed);
    end
    check_counters("random");
  endtask

  initial begin
    test_reset();
    test_cold_and_spatial();
    test_conflict();
    test_stall();
    test_reset_mid_fill();
    test_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
